// File: rtl/riscv_i32_trace_nybble_buffer_pkg.sv
// riscv_i32_trace_pkg
// Shared sizing constants and helpers for the trace nybble window buffer.
// Provides window/storage/word sizes in nybbles, the width of the consume
// amount, a typed nybble-count alias and a small minimum helper.
// No ports (package).

package riscv_i32_trace_pkg;

  localparam int TRACE_WINDOW_NYBBLES = 16;
  localparam int TRACE_BUFFER_NYBBLES = 24;
  localparam int TRACE_WORD_NYBBLES   = 8;

  // Width of nybble counts and of the decompressor's consume amount (1..31).
  localparam int TRACE_CONSUME_W = 5;

  localparam int TRACE_WINDOW_BITS = 4 * TRACE_WINDOW_NYBBLES;
  localparam int TRACE_BUFFER_BITS = 4 * TRACE_BUFFER_NYBBLES;
  localparam int TRACE_WORD_BITS   = 4 * TRACE_WORD_NYBBLES;

  typedef logic [TRACE_CONSUME_W-1:0] nyb_count_t;

  localparam nyb_count_t WINDOW_CNT = nyb_count_t'(TRACE_WINDOW_NYBBLES);
  localparam nyb_count_t WORD_CNT   = nyb_count_t'(TRACE_WORD_NYBBLES);

  // Smaller of two nybble counts; used to clamp over-consumes to what is held.
  function automatic nyb_count_t minCount(input nyb_count_t a, input nyb_count_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/riscv_i32_trace_nybble_buffer_if.sv
// riscv_i32_trace_nybble_buffer_if
// Groups the word-input handshake and the decompressor-facing window signals
// of the trace nybble buffer.
//   in_valid / in_data / in_ack : 32-bit compressed word handshake
//   in_flush                    : end-of-stream pulse
//   compressed_nybbles          : 64-bit window, nybble 0 in [3:0]
//   window_valid                : window may be decoded/consumed this cycle
//   nybble_count                : nybbles held (0..24)
//   consume / nybbles_consumed  : decompressor consume request and amount
// Modports: master = producer/decompressor side, slave = the buffer.

interface riscv_i32_trace_nybble_buffer_if;
  import riscv_i32_trace_pkg::*;

  logic                         in_valid;
  logic [TRACE_WORD_BITS-1:0]   in_data;
  logic                         in_ack;
  logic                         in_flush;
  logic [TRACE_WINDOW_BITS-1:0] compressed_nybbles;
  logic                         window_valid;
  nyb_count_t                   nybble_count;
  logic                         consume;
  nyb_count_t                   nybbles_consumed;

  modport master (
    output in_valid, in_data, in_flush, consume, nybbles_consumed,
    input  in_ack, compressed_nybbles, window_valid, nybble_count
  );

  modport slave (
    input  in_valid, in_data, in_flush, consume, nybbles_consumed,
    output in_ack, compressed_nybbles, window_valid, nybble_count
  );

endinterface

// File: rtl/riscv_i32_trace_nybble_buffer_shift.sv
// riscv_i32_trace_nybble_shift
// Combinational right shifter for the nybble storage: moves the 96-bit
// storage down by amt_i nybbles (0..24), filling zeros from the top.
//   data_i : storage contents, nybble 0 in [3:0]
//   amt_i  : shift amount in nybbles
//   data_o : shifted storage

module riscv_i32_trace_nybble_shift
  import riscv_i32_trace_pkg::*;
(
  input  logic [TRACE_BUFFER_BITS-1:0] data_i,
  input  nyb_count_t                   amt_i,
  output logic [TRACE_BUFFER_BITS-1:0] data_o
);

  // Amounts of 24 or more shift everything out, which leaves all zeros.
  assign data_o = data_i >> {amt_i, 2'b00};

endmodule

// File: rtl/riscv_i32_trace_nybble_buffer.sv
// riscv_i32_trace_nybble_buffer
// Nybble window buffer in front of the trace decompressor. Accepts 32-bit
// words of compressed trace, holds up to 24 nybbles, shows the lowest 16 as
// a window and drops nybbles from the bottom as the decompressor consumes
// them. An end-of-stream flush lets a short tail be decoded.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : riscv_i32_trace_nybble_buffer_if.slave (handshake + window)
//   stat_words, stat_discards : only with RISCV_I32_TRACE_NYBBLE_BUFFER_STATS_EN
//                               defined; saturating accept / over-consume counts
// Configuration macro: RISCV_I32_TRACE_NYBBLE_BUFFER_STATS_EN

module riscv_i32_trace_nybble_buffer
  import riscv_i32_trace_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  riscv_i32_trace_nybble_buffer_if.slave bus
`ifdef RISCV_I32_TRACE_NYBBLE_BUFFER_STATS_EN
  ,
  output logic [15:0] stat_words,
  output logic [15:0] stat_discards
`endif
);

  logic [TRACE_BUFFER_BITS-1:0] data_q, data_d;
  nyb_count_t                   count_q, count_d;
  logic                         flush_q, flush_d;

  logic                         inAck;
  logic                         windowValid;
  logic                         accept;
  nyb_count_t                   consumeAmt;
  nyb_count_t                   countAfter;
  logic [TRACE_BUFFER_BITS-1:0] shiftedData;
  logic [TRACE_BUFFER_BITS-1:0] placedWord;

  // Accept gate depends on state only, so a full word always fits (16+8=24).
  assign inAck       = (count_q <= WINDOW_CNT);
  assign windowValid = (count_q >= WINDOW_CNT) | (flush_q & (count_q != '0));
  assign accept      = bus.in_valid & inAck;

  // Consume amount is clamped to the held count so an over-consume (including
  // the idle code 31) simply empties the buffer.
  always_comb begin
    consumeAmt = '0;
    if (bus.consume && windowValid) begin
      consumeAmt = minCount(bus.nybbles_consumed, count_q);
    end
  end

  riscv_i32_trace_nybble_shift u_shift (
    .data_i (data_q),
    .amt_i  (consumeAmt),
    .data_o (shiftedData)
  );

  assign countAfter = count_q - consumeAmt;

  // The new word lands directly above the surviving nybbles. Everything above
  // the count is zero, so OR-ing it in is safe.
  assign placedWord = {{(TRACE_BUFFER_BITS-TRACE_WORD_BITS){1'b0}}, bus.in_data}
                      << {countAfter, 2'b00};

  // Next state: consume first, then append; flush stays pending until the
  // buffer would go empty without a new word arriving.
  always_comb begin
    data_d  = shiftedData;
    count_d = countAfter;
    if (accept) begin
      data_d  = shiftedData | placedWord;
      count_d = countAfter + WORD_CNT;
    end
    flush_d = (flush_q | bus.in_flush) & (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q  <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      flush_q <= flush_d;
    end
  end

  assign bus.in_ack             = inAck;
  assign bus.window_valid       = windowValid;
  assign bus.compressed_nybbles = data_q[TRACE_WINDOW_BITS-1:0];
  assign bus.nybble_count       = count_q;

`ifdef RISCV_I32_TRACE_NYBBLE_BUFFER_STATS_EN
  logic [15:0] statWords_q, statDiscards_q;
  logic        overConsume;

  // Over-consume means the decompressor asked for more than was held.
  assign overConsume = bus.consume & windowValid & (bus.nybbles_consumed > count_q);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      statWords_q    <= '0;
      statDiscards_q <= '0;
    end else begin
      if (accept && (statWords_q != 16'hFFFF)) begin
        statWords_q <= statWords_q + 16'd1;
      end
      if (overConsume && (statDiscards_q != 16'hFFFF)) begin
        statDiscards_q <= statDiscards_q + 16'd1;
      end
    end
  end

  assign stat_words    = statWords_q;
  assign stat_discards = statDiscards_q;
`endif

endmodule

// File: doc/riscv_i32_trace_nybble_buffer.md
# riscv_i32_trace_nybble_buffer

Nybble window buffer sitting directly upstream of `riscv_i32_trace_decompression`. It accepts 32-bit words of compressed trace (8 nybbles each, nybble 0 in bits [3:0]) over a valid/ack handshake and holds up to 24 nybbles. It presents the lowest 16 as the 64-bit `compressed_nybbles` window, then discards nybbles from the bottom as the decompressor reports `nybbles_consumed`. It turns the decompressor's combinational consume count into a registered shift register with flow control and end-of-stream flush.

## Interface
- No parameters; window 16 nybbles, storage 24 nybbles, input word 8 nybbles (package constants).
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  `in_data` holds a word
- `in_data`  in  32  8 compressed nybbles, nybble 0 = [3:0]
- `in_ack`  out  1  word accepted this cycle when `in_valid & in_ack`
- `in_flush`  in  1  end-of-stream pulse; drain remaining nybbles without waiting for a full window
- `compressed_nybbles`  out  64  nybbles 0..15 of storage; nybbles at index ≥ count read as 0
- `window_valid`  out  1  window may be decoded and consumed this cycle
- `nybble_count`  out  5  nybbles held, 0..24
- `consume`  in  1  apply `nybbles_consumed` this cycle; ignored unless `window_valid`
- `nybbles_consumed`  in  5  from decompressor, 1..31

## Operation
- State: `data[95:0]`, `count[4:0]`, `flush_pending`. Invariant: every nybble at index ≥ count is 0.
- `in_ack = (count <= 16)`. This is a function of state only, never of `in_valid` or `consume`.
- `window_valid = (count >= 16) | (flush_pending & count != 0)`.
- Consume amount `c = (consume & window_valid) ? min(nybbles_consumed, count) : 0`. Any value ≥ count, including 31 (the all-zero idle code), empties the buffer.
- Next state, with consume applied before append:
  - shift `data` right by 4·c, zero-filling from the top;
  - `count' = count − c`;
  - if a word is accepted, OR `in_data` into nybbles [count'..count'+7] and add 8 to `count'`.
- `flush_pending` is set by `in_flush`. It is cleared on the cycle `count` would become 0 with no word accepted. `in_flush` together with `count == 0` and no accept leaves it clear.
- `in_flush` while a word is accepted: the word is included in the drain.
- Arithmetic is 5-bit unsigned; `count` never exceeds 24 because the accept gate is ≤ 16.

## Timing
- All outputs are registered state or a combinational function of state only. No input-to-output combinational path apart from the registered loop through the decompressor.
- Reset values: `data = 0`, `count = 0`, `flush_pending = 0`, `in_ack = 1`, `window_valid = 0`, `compressed_nybbles = 0`, `nybble_count = 0`.
- Latency: an accepted word is visible in `compressed_nybbles` the next cycle.
- Throughput: one word per cycle while `count ≤ 16`. A consume and an accept in the same cycle are both honoured.
- Reset asserted mid-stream discards all data and any pending flush on the next edge.

## Configuration
- `RISCV_I32_TRACE_NYBBLE_BUFFER_STATS_EN` defined: adds two outputs, each resetting to 0.
  - `stat_words[15:0]`: saturating count of accepted words.
  - `stat_discards[15:0]`: saturating count of cycles where `nybbles_consumed > count` was applied.
- Macro undefined: neither port nor its counters exist. Behaviour is otherwise identical.

## Structure
- The package `riscv_i32_trace_pkg` holds:
  - constants `TRACE_WINDOW_NYBBLES = 16`, `TRACE_BUFFER_NYBBLES = 24`, `TRACE_WORD_NYBBLES = 8`;
  - the consume-amount width.
- One sub-module is natural: `riscv_i32_trace_nybble_shift`. It is a combinational 96-bit right shifter by 0..24 nybbles with zero fill, used for the consume path. The append uses a second instance-free left placement.

## Test plan
- Reset, then 2 words `0x76543211`, `0xFEDCBA98` -> `in_ack` high both cycles; count 16; `window_valid = 1`; `compressed_nybbles = 0xFEDCBA9876543211`.
- Window full; consume 3 and accept `0x0000000A` in the same cycle -> count 21; nybbles 13..20 = `A,0,...`; window shifted by 3 nybbles.
- Fill to 24 -> `in_ack` low, `in_valid` held with no accept; consume 8 -> `in_ack` high the next cycle.
- 5 nybbles held, `in_flush` -> `window_valid` next cycle; upper 11 window nybbles are 0. Consume 31 -> count 0, `flush_pending` clear, `window_valid` low.
- `consume` high while `window_valid` low (count 9, no flush) -> no change to count or data.
- With the STATS macro: 3 accepts plus one over-consume -> `stat_words = 3`, `stat_discards = 1`. Counters saturate at `0xFFFF`.
